// File: rtl/nzcv_flag_unit.sv
// rtl/nzcv_flag_unit.sv - NZCV status register producer with shadow copy and direct writes
// Flags packed {Z,C,N,V}; ALU, MSR and exception paths update on the rising edge.
module nzcv_flag_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_upd_valid,
  input  logic [2:0]            i_upd_op,
  input  logic                  i_upd_s_bit,
  input  logic                  i_upd_cond_pass,
  input  logic                  i_upd_flush,
  input  logic [DATA_WIDTH-1:0] i_operand_a,
  input  logic [DATA_WIDTH-1:0] i_operand_b,
  input  logic [DATA_WIDTH-1:0] i_logic_result,
  input  logic                  i_shifter_carry,
  input  logic                  i_msr_we,
  input  logic [3:0]            i_msr_flags,
  input  logic                  i_exc_entry,
  input  logic                  i_exc_return,
  output logic [3:0]            o_status_register,
  output logic [3:0]            o_saved_flags,
  output logic                  o_flags_updated
);

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_ADC   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_SBC   = 3'd3;
  localparam logic [2:0] OP_RSB   = 3'd4;
  localparam logic [2:0] OP_LOGIC = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;

  logic [3:0]            r_status;
  logic [3:0]            r_saved;
  logic                  r_flags_updated;

  logic [DATA_WIDTH-1:0] w_x;
  logic [DATA_WIDTH-1:0] w_y;
  logic                  w_cin;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_arith_v;
  logic                  w_op_valid;
  logic [3:0]            w_alu_flags;
  logic                  w_alu_commit;

  wire w_cur_c = r_status[2];

  // Every arithmetic op is one adder: pick addends and carry-in per opcode.
  always_comb begin
    w_x        = i_operand_a;
    w_y        = i_operand_b;
    w_cin      = 1'b0;
    w_op_valid = 1'b1;
    case (i_upd_op)
      OP_ADD:   w_cin = 1'b0;
      OP_ADC:   w_cin = w_cur_c;
      OP_SUB:   begin w_y = ~i_operand_b; w_cin = 1'b1;    end
      OP_SBC:   begin w_y = ~i_operand_b; w_cin = w_cur_c; end
      OP_RSB:   begin w_x = i_operand_b; w_y = ~i_operand_a; w_cin = 1'b1; end
      OP_LOGIC: w_cin = 1'b0;
      OP_MUL:   w_cin = 1'b0;
      default:  w_op_valid = 1'b0;
    endcase
  end

  assign w_sum     = {1'b0, w_x} + {1'b0, w_y} + {{DATA_WIDTH{1'b0}}, w_cin};
  assign w_res     = w_sum[DATA_WIDTH-1:0];
  assign w_arith_v = (w_x[DATA_WIDTH-1] == w_y[DATA_WIDTH-1]) &&
                     (w_res[DATA_WIDTH-1] != w_x[DATA_WIDTH-1]);

  always_comb begin
    w_alu_flags = r_status;
    case (i_upd_op)
      OP_LOGIC: w_alu_flags = {(i_logic_result == '0), i_shifter_carry,
                               i_logic_result[DATA_WIDTH-1], r_status[0]};
      OP_MUL:   w_alu_flags = {(i_logic_result == '0), r_status[2],
                               i_logic_result[DATA_WIDTH-1], r_status[0]};
      default:  w_alu_flags = {(w_res == '0), w_sum[DATA_WIDTH],
                               w_res[DATA_WIDTH-1], w_arith_v};
    endcase
  end

  assign w_alu_commit = i_upd_valid & i_upd_s_bit & i_upd_cond_pass & ~i_upd_flush &
                        ~i_exc_entry & ~i_exc_return & ~i_msr_we & w_op_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status        <= 4'b0000;
      r_saved         <= 4'b0000;
      r_flags_updated <= 1'b0;
    end else begin
      r_flags_updated <= 1'b0;
      if (i_exc_entry) begin
        r_saved <= r_status;
      end else if (i_exc_return) begin
        r_status        <= r_saved;
        r_flags_updated <= 1'b1;
      end else if (i_msr_we) begin
        r_status        <= i_msr_flags;
        r_flags_updated <= 1'b1;
      end else if (w_alu_commit) begin
        r_status        <= w_alu_flags;
        r_flags_updated <= 1'b1;
      end
    end
  end

  assign o_status_register = r_status;
  assign o_saved_flags     = r_saved;
  assign o_flags_updated   = r_flags_updated;

endmodule

// File: tb/tb_nzcv_flag_unit.sv
// tb/tb_nzcv_flag_unit.sv - directed self-checking bench for nzcv_flag_unit
module tb_nzcv_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_valid, upd_s_bit, upd_cond_pass, upd_flush;
  logic [2:0]  upd_op;
  logic [31:0] operand_a, operand_b, logic_result;
  logic        shifter_carry, msr_we, exc_entry, exc_return;
  logic [3:0]  msr_flags;
  logic [3:0]  status_register, saved_flags;
  logic        flags_updated;

  int checks = 0;
  int failures = 0;

  nzcv_flag_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_upd_valid(upd_valid), .i_upd_op(upd_op), .i_upd_s_bit(upd_s_bit),
    .i_upd_cond_pass(upd_cond_pass), .i_upd_flush(upd_flush),
    .i_operand_a(operand_a), .i_operand_b(operand_b),
    .i_logic_result(logic_result), .i_shifter_carry(shifter_carry),
    .i_msr_we(msr_we), .i_msr_flags(msr_flags),
    .i_exc_entry(exc_entry), .i_exc_return(exc_return),
    .o_status_register(status_register), .o_saved_flags(saved_flags),
    .o_flags_updated(flags_updated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    upd_valid = 0; upd_op = 3'd0; upd_s_bit = 1; upd_cond_pass = 1; upd_flush = 0;
    operand_a = 0; operand_b = 0; logic_result = 0; shifter_carry = 0;
    msr_we = 0; msr_flags = 0; exc_entry = 0; exc_return = 0;
  endtask

  task automatic alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    upd_valid = 1; upd_op = op; operand_a = a; operand_b = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_flags(input string tag, input logic [3:0] st, input logic fu);
    chk({tag, "_status"}, {28'd0, status_register}, {28'd0, st});
    chk({tag, "_pulse"},  {31'd0, flags_updated},   {31'd0, fu});
  endtask

  initial begin
    rst_n = 0;
    upd_valid = 1; upd_op = 3'd0; upd_s_bit = 1; upd_cond_pass = 1; upd_flush = 1;
    operand_a = '1; operand_b = '1; logic_result = '1; shifter_carry = 1;
    msr_we = 1; msr_flags = 4'hF; exc_entry = 1; exc_return = 1;
    #1;
    expect_flags("reset_t0", 4'b0000, 1'b0);
    chk("reset_t0_saved", {28'd0, saved_flags}, 32'd0);
    step();
    expect_flags("reset_held", 4'b0000, 1'b0);
    chk("reset_held_saved", {28'd0, saved_flags}, 32'd0);

    idle(); alu(3'd0, 32'hFFFF_FFFF, 32'h1);
    rst_n = 1;
    step();
    expect_flags("add_wrap", 4'b1100, 1'b1);
    chk("add_wrap_saved", {28'd0, saved_flags}, 32'd0);

    alu(3'd0, 32'h7FFF_FFFF, 32'h1);            step(); expect_flags("add_ovf", 4'b0011, 1'b1);
    alu(3'd2, 32'd5, 32'd5);                    step(); expect_flags("sub_eq", 4'b1100, 1'b1);
    alu(3'd2, 32'd3, 32'd5);                    step(); expect_flags("sub_neg", 4'b0010, 1'b1);
    alu(3'd3, 32'd10, 32'd3);                   step(); expect_flags("sbc", 4'b0100, 1'b1);
    alu(3'd1, 32'd0, 32'd0);                    step(); expect_flags("adc_chain", 4'b0000, 1'b1);
    alu(3'd4, 32'd5, 32'd3);                    step(); expect_flags("rsb_neg", 4'b0010, 1'b1);
    alu(3'd4, 32'd3, 32'd5);                    step(); expect_flags("rsb_pos", 4'b0100, 1'b1);

    idle(); msr_we = 1; msr_flags = 4'b0001;    step(); expect_flags("msr_v", 4'b0001, 1'b1);
    idle(); alu(3'd5, 32'd0, 32'd0); logic_result = 32'd0; shifter_carry = 1;
    step(); expect_flags("logic_zero", 4'b1101, 1'b1);

    for (int v = 0; v < 4; v++) begin
      idle(); alu(3'd5, 32'd0, 32'd0); logic_result = 32'h0000_FFFF; shifter_carry = 0;
      case (v)
        0: upd_s_bit = 0;
        1: upd_cond_pass = 0;
        2: upd_flush = 1;
        default: upd_op = 3'd7;
      endcase
      step();
      expect_flags($sformatf("gate%0d", v), 4'b1101, 1'b0);
    end

    idle(); alu(3'd6, 32'd0, 32'd0); logic_result = 32'h8000_0000;
    step(); expect_flags("mul", 4'b0111, 1'b1);

    idle(); msr_we = 1; msr_flags = 4'b1010;    step(); expect_flags("msr_1010", 4'b1010, 1'b1);
    idle(); exc_entry = 1; alu(3'd0, 32'd1, 32'd1);
    step();
    expect_flags("exc_entry", 4'b1010, 1'b0);
    chk("exc_entry_saved", {28'd0, saved_flags}, 32'hA);
    idle(); alu(3'd0, 32'd1, 32'd1);            step(); expect_flags("add_small", 4'b0000, 1'b1);
    idle(); msr_we = 1; msr_flags = 4'b0110; alu(3'd0, 32'd1, 32'd1);
    step(); expect_flags("msr_over_alu", 4'b0110, 1'b1);
    idle(); exc_return = 1;
    step();
    expect_flags("exc_return", 4'b1010, 1'b1);
    chk("exc_return_saved", {28'd0, saved_flags}, 32'hA);

    idle(); msr_we = 1; msr_flags = 4'b0011;    step(); expect_flags("msr_0011", 4'b0011, 1'b1);
    idle(); exc_entry = 1; exc_return = 1;
    step();
    expect_flags("entry_and_return", 4'b0011, 1'b0);
    chk("entry_and_return_saved", {28'd0, saved_flags}, 32'h3);

    idle(); alu(3'd0, 32'hFFFF_FFFF, 32'h1);
    rst_n = 0;
    #1;
    expect_flags("async_rst", 4'b0000, 1'b0);
    chk("async_rst_saved", {28'd0, saved_flags}, 32'd0);
    step();
    expect_flags("async_rst_edge", 4'b0000, 1'b0);
    idle(); rst_n = 1;
    step();
    expect_flags("after_rst_idle", 4'b0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
